// File: rtl/comparch_pkg.sv
// Shared architectural constants and types for the instruction fetch path.
// Imported by the prefetch buffer and its queue.
package comparch_pkg;

    localparam int          WORD_W        = 32;
    localparam int          DEFAULT_DEPTH = 4;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pf_queue.sv
// Circular FIFO holding fetched {pc, instr} entries for the prefetch buffer.
// Storage is not reset; only pointers and occupancy are.
module pf_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= wdata;
        end
    end

    assign rdata = mem[head];

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: fetches sequentially from memory into a small
// queue and presents the head to decode; a taken redirect flushes and refetches.
module inst_prefetch
    import comparch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_instr,
    input  logic              mem_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] inst_out,
    output logic [WORD_W-1:0] pc_out,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] fpc;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign full       = (count == CNT_W'(DEPTH));
    assign inst_valid = (count != '0);

    // Redirect squashes both sides of the handshake; pop frees a slot for a push.
    assign pop  = inst_valid && inst_ready && !redirect;
    assign push = mem_ready && !redirect && (!full || pop);

    assign push_entry = '{pc: fpc, instr: mem_instr};

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc <= RESET_PC;
        end else if (redirect) begin
            fpc <= align_word(redirect_pc);
        end else if (push) begin
            fpc <= fpc + PC_INC;
        end
    end

    pf_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (count)
    );

    assign mem_addr = fpc;
    assign inst_out = head_entry.instr;
    assign pc_out   = head_entry.pc;

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: a queue-based reference of the fetch buffer checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_inst_prefetch;

    logic        clk;
    logic        rst;
    logic        mem_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic [31:0] mem_addr, mem_instr, inst_out, pc_out;
    logic        inst_valid;
    logic [31:0] mem_addr_w, mem_instr_w, inst_out_w, pc_out_w;
    logic        inst_valid_w;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C96E1;
    endfunction

    assign mem_instr   = memf(mem_addr);
    assign mem_instr_w = memf(mem_addr_w);

    inst_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_instr   (mem_instr),
        .mem_ready   (mem_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_out    (inst_out),
        .pc_out      (pc_out),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
    );

    // Second instance only exercises the wrapping reset address.
    inst_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFFFFF8)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr_w),
        .mem_instr   (mem_instr_w),
        .mem_ready   (mem_ready),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .inst_out    (inst_out_w),
        .pc_out      (pc_out_w),
        .inst_valid  (inst_valid_w),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of {pc, instr} entries plus a fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_fpc = 32'h0;
    bit          m_pop, m_push;

    always @(posedge clk) begin
        if (rst) begin
            m_fpc = 32'h0;
            mq.delete();
        end else if (redirect) begin
            mq.delete();
            m_fpc = redirect_pc & 32'hFFFFFFFC;
        end else begin
            m_pop  = (mq.size() != 0) && inst_ready;
            m_push = mem_ready && ((mq.size() < 4) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({m_fpc, memf(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_addr", mem_addr, m_fpc);
            check("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("pc_out", pc_out, mq[0][63:32]);
                check("inst_out", inst_out, mq[0][31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rtab [4] = '{32'hFFFFFFF5, 32'h00001002, 32'h00000040, 32'hFFFFFFF0};

    initial begin
        rst = 1'b1; mem_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);

        // Fill with consumer stalled: addresses 0,4,8,12 fetched, then hold at 16.
        rst = 1'b0; mem_ready = 1'b1; inst_ready = 1'b0;
        check("fill_addr0", mem_addr, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("fill_addr", mem_addr, (k <= 4) ? 32'(4 * k) : 32'd16);
        end
        check("fill_pc", pc_out, 32'h0);
        check("fill_valid", {31'b0, inst_valid}, 32'd1);
        check("fill_count", 32'(mq.size()), 32'd4);

        // Full queue streaming: one pop and one push per cycle.
        inst_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("stream_pc", pc_out, 32'(4 * k));
            check("stream_count", 32'(mq.size()), 32'd4);
        end

        // Redirect with misaligned target while full.
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        check("redir_valid", {31'b0, inst_valid}, 32'd0);
        check("redir_addr", mem_addr, 32'h100);
        tick();
        check("redir_pc", pc_out, 32'h100);
        check("redir_valid2", {31'b0, inst_valid}, 32'd1);

        // mem_ready pattern 1,0,0,1 with consumer always ready.
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b1; inst_ready = 1'b1;
        tick();
        check("gap_pc0", pc_out, 32'h0);
        mem_ready = 1'b0;
        tick();
        check("gap_valid1", {31'b0, inst_valid}, 32'd0);
        tick();
        check("gap_valid2", {31'b0, inst_valid}, 32'd0);
        check("gap_addr", mem_addr, 32'h4);
        mem_ready = 1'b1;
        tick();
        check("gap_pc4", pc_out, 32'h4);
        check("gap_valid3", {31'b0, inst_valid}, 32'd1);

        // Reset address near the top of the space wraps through zero.
        rst = 1'b1;
        tick();
        check("wrap_rst_addr", mem_addr_w, 32'hFFFFFFF8);
        check("wrap_rst_valid", {31'b0, inst_valid_w}, 32'd0);
        rst = 1'b0; mem_ready = 1'b1; inst_ready = 1'b1;
        tick();
        check("wrap_pc0", pc_out_w, 32'hFFFFFFF8);
        check("wrap_ins0", inst_out_w, memf(32'hFFFFFFF8));
        tick();
        check("wrap_pc1", pc_out_w, 32'hFFFFFFFC);
        tick();
        check("wrap_pc2", pc_out_w, 32'h00000000);
        check("wrap_ins2", inst_out_w, memf(32'h0));
        check("wrap_addr", mem_addr_w, 32'h4);

        // Reset wins over a simultaneous redirect with entries queued.
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b1; inst_ready = 1'b0;
        tick(); tick(); tick();
        check("pri_count3", 32'(mq.size()), 32'd3);
        check("pri_pc", pc_out, 32'h0);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        rst = 1'b0; redirect = 1'b0;
        check("pri_valid", {31'b0, inst_valid}, 32'd0);
        check("pri_addr", mem_addr, 32'h0);
        check("pri_count0", 32'(mq.size()), 32'd0);

        // Mixed traffic with periodic redirects, including across the wrap point.
        for (int i = 0; i < 80; i++) begin
            mem_ready   = (i % 3) != 1;
            inst_ready  = (i % 5) < 3;
            redirect    = (i % 19) == 18;
            redirect_pc = rtab[(i / 19) % 4];
            tick();
        end
        redirect = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
